// File: rtl/lab1_bit_serializer.sv
// Byte-to-bit serializer: valid/ready push into a small FIFO, words shifted out MSB first,
// one bit per enabled clock, with back-to-back words and no bypass path.
module lab1_bit_serializer #(
  parameter int unsigned Width   = 8,
  parameter int unsigned Depth   = 4,
  parameter logic        IdleBit = 1'b0
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [Width-1:0]           InData,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic                       Enable,
  output logic                       SerialOut,
  output logic                       BitValid,
  output logic                       LastBit,
  output logic [$clog2(Depth):0]     Count,
  output logic                       Idle
);

  localparam int unsigned PW = $clog2(Depth);
  localparam int unsigned IW = $clog2(Width);
  localparam int unsigned CW = PW + 1;
  localparam logic [IW-1:0] LastIdx = IW'(Width - 1);
  localparam logic [CW-1:0] Full    = CW'(Depth);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [Width-1:0]  shreg_q, shreg_d;
  logic              serial_q, serial_d;
  logic              bit_valid_q, bit_valid_d;
  logic              last_bit_q, last_bit_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]  mem [Depth];

  logic push, pop, load, fifo_empty;

  assign InReady    = (count_q != Full);
  assign push       = InValid && InReady;
  assign fifo_empty = (count_q == '0);

  // Pop decisions use the pre-edge count, so a word pushed this edge is never popped this edge.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    serial_d    = serial_q;
    bit_valid_d = 1'b0;
    last_bit_d  = last_bit_q;
    load        = 1'b0;
    if (Enable) begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            serial_d   = IdleBit;
            last_bit_d = 1'b0;
          end
        end
        StShift: begin
          if (idx_q != LastIdx) begin
            shreg_d     = {shreg_q[Width-2:0], 1'b0};
            serial_d    = shreg_q[Width-2];
            idx_d       = idx_q + IW'(1);
            bit_valid_d = 1'b1;
            last_bit_d  = ((idx_q + IW'(1)) == LastIdx);
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d    = StIdle;
            serial_d   = IdleBit;
            last_bit_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    if (load) begin
      state_d     = StShift;
      shreg_d     = mem[rd_ptr_q];
      serial_d    = mem[rd_ptr_q][Width-1];
      idx_d       = '0;
      bit_valid_d = 1'b1;
      last_bit_d  = 1'b0;
    end
  end

  assign pop = load;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      shreg_q     <= '0;
      serial_q    <= IdleBit;
      bit_valid_q <= 1'b0;
      last_bit_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      serial_q    <= serial_d;
      bit_valid_q <= bit_valid_d;
      last_bit_q  <= last_bit_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge Clock) begin
    if (push) mem[wr_ptr_q] <= InData;
  end

  assign SerialOut = serial_q;
  assign BitValid  = bit_valid_q;
  assign LastBit   = last_bit_q;
  assign Count     = count_q;
  assign Idle      = fifo_empty && (state_q == StIdle);

endmodule

// File: doc/lab1_bit_serializer.md
# lab1_bit_serializer

Byte-to-bit serializer that sits directly upstream of the 1010 sequence-detector FSM and drives its serial `In` input. Parallel bytes are accepted over a valid/ready handshake into a small FIFO, then shifted out MSB first, one bit per enabled clock. This replaces file-driven bit stimulus with a synthesizable source that can be fed by a byte producer.

## Interface
- `Width`, 8: bits per word; must be ≥ 2.
- `Depth`, 4: FIFO depth in words; a power of two, ≥ 2.
- `IdleBit`, 1'b0: level driven on `SerialOut` when no bit is being presented.

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `InData`  in  `Width`  word to serialize; bit `Width-1` is transmitted first.
- `InValid`  in  1  `InData` is valid this cycle.
- `InReady`  out  1  FIFO can accept a word; equals (`Count != Depth`), combinational from `Count`.
- `Enable`  in  1  output-side advance enable; low stalls the serializer.
- `SerialOut`  out  1  serial bit to the detector's `In`; registered.
- `BitValid`  out  1  `SerialOut` carries a new bit this cycle; registered.
- `LastBit`  out  1  high with the final bit (LSB) of a word; registered.
- `Count`  out  clog2(`Depth`)+1  FIFO occupancy, 0..`Depth`.
- `Idle`  out  1  FIFO empty and no word in the shifter.

## Operation
- Push: on an edge where `InValid && InReady`, write `InData` at the write pointer and increment the pointer modulo `Depth`. When `InReady` is low, `InValid` is ignored and no data is lost or overwritten.
- Pop: the shifter pops a word only on an edge with `Enable=1` when it is free, or when it is presenting its last bit. Pop loads the word into the shift register and sets bit index 0. Increment the read pointer modulo `Depth`.
- `Count`: +1 on push only, -1 on pop only, unchanged on push and pop together.
- No bypass: a word pushed at edge k is not visible to the pop logic until after edge k. This holds even when the FIFO is empty.
- Shifter states:
  - IDLE: `Busy=0`, `SerialOut=IdleBit`, `BitValid=0`.
  - SHIFT: `Busy=1`, `SerialOut` = current bit, index 0..`Width-1`.
- Transitions on an edge with `Enable=1`:
  - IDLE and FIFO non-empty → SHIFT. Pop, present the MSB, set `BitValid=1`.
  - IDLE and FIFO empty → stay in IDLE.
  - SHIFT with index < `Width-1` → shift left, index+1, `BitValid=1`. `LastBit=1` when the new index is `Width-1`.
  - SHIFT with index = `Width-1` and FIFO non-empty → pop and present the next MSB back-to-back with no gap. `LastBit=0`.
  - SHIFT with index = `Width-1` and FIFO empty → IDLE. Set `SerialOut=IdleBit`, `BitValid=0`, `LastBit=0`.
- On an edge with `Enable=0`: `BitValid<=0`. `SerialOut`, `LastBit`, the index and state hold, and no pop occurs. Pushes still proceed.
- `Idle` = (`Count==0`) && !`Busy`.
- Reset (asynchronous, any time including mid-word and mid-push): all buffered words are discarded, and outputs take their reset values below. Operation restarts cleanly on the first edge after `Reset` falls.

## Timing
- Reset values:
  - `SerialOut=IdleBit`, `BitValid=0`, `LastBit=0`.
  - `Count=0`, `InReady=1`, `Idle=1`.
  - Pointers 0, shifter in IDLE.
- Latency: a word pushed at edge k with the shifter in IDLE and `Enable` high presents its MSB after edge k+1. The word's `Width` bits occupy `Width` consecutive enabled cycles.
- Throughput: one bit per enabled cycle. There are no bubbles between words while the FIFO is non-empty.
- `InReady` reflects `Count` after the current edge. Once a pop occurs, a full FIFO accepts a push on the next edge.
- `BitValid` is high for exactly one cycle per bit. A consumer that advances every clock must hold `Enable=1`.

## Test plan
- Reset check: assert `Reset` asynchronously between edges. The outputs change immediately to `SerialOut=0`, `BitValid=0`, `Count=0`, `InReady=1`, `Idle=1`.
- Single word: push 8'b10100000 at edge k with `Enable=1`. From edge k+1 `SerialOut` reads 1,0,1,0,0,0,0,0 with `BitValid=1`, and `LastBit=1` on the 8th bit only. After edge k+9 the block returns to `BitValid=0`, `Idle=1`. Feeding the detector produces its 1010 match.
- Back-to-back and full: hold `Enable=0` and push 8'hA5, 8'h5A, 8'hF0, 8'h0F, then attempt to push 8'hFF. `Count=4` and `InReady=0`, and 8'hFF is dropped. Raise `Enable`: the 32 output bits are 10100101 01011010 11110000 00001111 with no gap, and `Count` steps down 4→3→2→1→0, decrementing at each word load.
- Stall: during 8'hC3, drop `Enable` after the 3rd bit for 5 cycles. `BitValid=0` and `SerialOut` holds 0 throughout. The remaining bits 00011 resume on re-enable, and the total bit count is 8.
- Simultaneous push/pop: with `Count=2`, push on the same edge the shifter loads the next word. `Count` stays 2 and data order is preserved.
- Mid-word reset: assert `Reset` after the 4th bit of 8'h96 while `Count=2`. All data is discarded. After release, push 8'h80 and the output is exactly 1,0,0,0,0,0,0,0.
